// File: rtl/tlut_argmax_stage.sv
// tlut_argmax_stage: waits out the SIMD cell latency, snapshots the
// accumulators, scans them one per cycle and returns argmax + score.
// Ports: clk, rst_n (async, active low), start, acc_in[NUM_OUT][ACC_WIDTH],
//   busy, result_valid/result_ready, class_idx, class_score, start_dropped.
// Option: `TLUT_ARGMAX_RUNNER_UP_EN adds second_idx and margin outputs.
module tlut_argmax_stage #(
   parameter int NUM_OUT        = 10,
   parameter int ACC_WIDTH      = 24,
   parameter int COMPUTE_CYCLES = 40,
   parameter int IDX_WIDTH      = $clog2(NUM_OUT)
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              start,
   input  logic [NUM_OUT-1:0][ACC_WIDTH-1:0] acc_in,
   output logic                              busy,
   output logic                              result_valid,
   input  logic                              result_ready,
   output logic [IDX_WIDTH-1:0]              class_idx,
   output logic [ACC_WIDTH-1:0]              class_score,
   output logic                              start_dropped
`ifdef TLUT_ARGMAX_RUNNER_UP_EN
   ,
   output logic [IDX_WIDTH-1:0]              second_idx,
   output logic [ACC_WIDTH:0]                margin
`endif
);

   localparam int CW = $clog2(COMPUTE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(COMPUTE_CYCLES - 1);
   localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(NUM_OUT - 1);

   typedef enum logic [1:0] {
      S_IDLE, S_WAIT, S_SCAN, S_HOLD
   } state_t;

   state_t state_q, state_d;

   logic [CW-1:0]                     cnt_q;
   logic [IDX_WIDTH-1:0]              ptr_q;
   logic [NUM_OUT-1:0][ACC_WIDTH-1:0] shadow_q;
   logic signed [ACC_WIDTH-1:0]       best_q, best_d, v;
   logic [IDX_WIDTH-1:0]              bidx_q, bidx_d;
   logic [IDX_WIDTH-1:0]              idx_q;
   logic [ACC_WIDTH-1:0]              score_q;

   logic accept, capture, scan, last;

   // HOLD with a completing handshake may start the next op directly.
   assign accept  = start && (state_q == S_IDLE ||
                    (state_q == S_HOLD && result_ready));
   assign capture = (state_q == S_WAIT) && (cnt_q == '0);
   assign scan    = (state_q == S_SCAN);
   assign last    = scan && (ptr_q == LAST);

`ifdef TLUT_ARGMAX_RUNNER_UP_EN
   localparam logic signed [ACC_WIDTH-1:0] MIN_V =
      {1'b1, {(ACC_WIDTH-1){1'b0}}};
   logic signed [ACC_WIDTH-1:0] sec_q, sec_d;
   logic [IDX_WIDTH-1:0]        sidx_q, sidx_d, sidx_o_q;
   logic [ACC_WIDTH:0]          margin_q;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (start) state_d = S_WAIT;
         S_WAIT: if (cnt_q == '0) state_d = S_SCAN;
         S_SCAN: if (ptr_q == LAST) state_d = S_HOLD;
         S_HOLD: if (result_ready)
            state_d = start ? S_WAIT : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      busy          = (state_q != S_IDLE);
      result_valid  = (state_q == S_HOLD);
      start_dropped = start && !accept && (state_q != S_IDLE);
   end

   // One scan step; ties keep the earlier (lower) index.
   always_comb begin
      v      = shadow_q[ptr_q];
      best_d = best_q;
      bidx_d = bidx_q;
`ifdef TLUT_ARGMAX_RUNNER_UP_EN
      sec_d  = sec_q;
      sidx_d = sidx_q;
`endif
      if (v > best_q) begin
         best_d = v;
         bidx_d = ptr_q;
`ifdef TLUT_ARGMAX_RUNNER_UP_EN
         sec_d  = best_q;
         sidx_d = bidx_q;
      end else if (v > sec_q) begin
         sec_d  = v;
         sidx_d = ptr_q;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         ptr_q    <= '0;
         shadow_q <= '0;
         best_q   <= '0;
         bidx_q   <= '0;
         idx_q    <= '0;
         score_q  <= '0;
      end else begin
         if (accept) cnt_q <= CNT_LOAD;
         else if (state_q == S_WAIT && cnt_q != '0)
            cnt_q <= cnt_q - CW'(1);
         if (capture) begin
            shadow_q <= acc_in;
            best_q   <= acc_in[0];
            bidx_q   <= '0;
            ptr_q    <= IDX_WIDTH'(1);
         end else if (scan) begin
            best_q <= best_d;
            bidx_q <= bidx_d;
            ptr_q  <= ptr_q + IDX_WIDTH'(1);
         end
         // Result registers change only on entry to HOLD.
         if (last) begin
            idx_q   <= bidx_d;
            score_q <= best_d;
         end
      end
   end

   assign class_idx   = idx_q;
   assign class_score = score_q;

`ifdef TLUT_ARGMAX_RUNNER_UP_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sec_q    <= '0;
         sidx_q   <= '0;
         sidx_o_q <= '0;
         margin_q <= '0;
      end else begin
         if (capture) begin
            sec_q  <= MIN_V;
            sidx_q <= '0;
         end else if (scan) begin
            sec_q  <= sec_d;
            sidx_q <= sidx_d;
         end
         // best >= second, so the wrapped difference is the true margin.
         if (last) begin
            sidx_o_q <= sidx_d;
            margin_q <= {best_d[ACC_WIDTH-1], best_d} -
                        {sec_d[ACC_WIDTH-1], sec_d};
         end
      end
   end

   assign second_idx = sidx_o_q;
   assign margin     = margin_q;
`endif

endmodule

// File: tb/tb_tlut_argmax_stage.sv
// tb_tlut_argmax_stage: random and directed ops against an argmax model.
// Covers reset, latency, ties, backpressure, dropped starts, mid-op reset.
module tb_tlut_argmax_stage;

   localparam int NO  = 10;
   localparam int AW  = 24;
   localparam int CC  = 40;
   localparam int IW  = 4;
   localparam int LAT = CC + NO - 1;
   localparam logic signed [AW-1:0] MIN_V = {1'b1, {(AW-1){1'b0}}};
   localparam logic signed [AW-1:0] MAX_V = {1'b0, {(AW-1){1'b1}}};

   logic                       clk, rst_n, start, result_ready;
   logic [NO-1:0][AW-1:0]      acc_in;
   logic                       busy, result_valid, start_dropped;
   logic [IW-1:0]              class_idx;
   logic [AW-1:0]              class_score;
`ifdef TLUT_ARGMAX_RUNNER_UP_EN
   logic [IW-1:0]              second_idx;
   logic [AW:0]                margin;
`endif

   tlut_argmax_stage #(
      .NUM_OUT(NO), .ACC_WIDTH(AW), .COMPUTE_CYCLES(CC), .IDX_WIDTH(IW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .acc_in(acc_in),
      .busy(busy), .result_valid(result_valid),
      .result_ready(result_ready), .class_idx(class_idx),
      .class_score(class_score), .start_dropped(start_dropped)
`ifdef TLUT_ARGMAX_RUNNER_UP_EN
      , .second_idx(second_idx), .margin(margin)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;

   logic signed [AW-1:0] a [NO];
   logic [IW-1:0]        e_idx, e_sidx;
   logic [AW-1:0]        e_score;
   logic [AW:0]          e_margin;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: max value, first index holding it; runner-up is the
   // max of the rest (first index), index 0 if nothing beats the floor.
   task automatic model();
      logic signed [AW-1:0] m, sm;
      longint d;
      m = a[0];
      for (int j = 1; j < NO; j++) if (a[j] > m) m = a[j];
      e_idx = '0;
      for (int j = NO - 1; j >= 0; j--) if (a[j] == m) e_idx = IW'(j);
      e_score = m;
      sm = MIN_V;
      for (int j = 0; j < NO; j++)
         if (j != int'(e_idx) && a[j] > sm) sm = a[j];
      e_sidx = '0;
      if (sm != MIN_V)
         for (int j = NO - 1; j >= 0; j--)
            if (j != int'(e_idx) && a[j] == sm) e_sidx = IW'(j);
      d = longint'(m) - longint'(sm);
      e_margin = d[AW:0];
   endtask

   task automatic drive_acc();
      for (int k = 0; k < NO; k++) acc_in[k] = a[k];
   endtask

   task automatic garbage();
      for (int k = 0; k < NO; k++) acc_in[k] = AW'($urandom);
   endtask

   task automatic gen();
      int mode, t;
      mode = $urandom_range(0, 2);
      for (int k = 0; k < NO; k++) begin
         case (mode)
            0: a[k] = AW'($urandom);
            1: begin t = $urandom_range(0, 6); a[k] = AW'(t - 3); end
            default: begin
               t = $urandom_range(0, 2);
               a[k] = (t == 0) ? MIN_V : (t == 1) ? MAX_V : '0;
            end
         endcase
      end
   endtask

   // Called at a negedge; returns at the negedge after the start edge.
   task automatic start_op();
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   // n counts edges after the start edge; acc_in is garbage except
   // for the cycle feeding the capture edge.
   task automatic wait_result(input bit poke);
      int n = 0;
      while (!result_valid && n < 4 * LAT) begin
         if (n == CC - 1) drive_acc();
         else garbage();
         if (n == 1) check("busy_run", busy, 1);
         if (poke && n == 5) begin
            start = 1'b1;
            #1 check("drop_wait", start_dropped, 1);
         end
         @(posedge clk);
         @(negedge clk);
         start = 1'b0;
         n++;
      end
      check("latency", n, LAT);
   endtask

   task automatic check_result();
      check("valid", result_valid, 1);
      check("idx", class_idx, e_idx);
      check("score", class_score, e_score);
`ifdef TLUT_ARGMAX_RUNNER_UP_EN
      check("sidx", second_idx, e_sidx);
      check("margin", margin, e_margin);
`endif
   endtask

   task automatic finish_op();
      result_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      result_ready = 1'b0;
      check("valid_clr", result_valid, 0);
      check("busy_clr", busy, 0);
      check("idx_hold", class_idx, e_idx);
      check("score_hold", class_score, e_score);
   endtask

   task automatic run(input bit poke);
      drive_acc();
      model();
      start_op();
      wait_result(poke);
      check_result();
      finish_op();
   endtask

   task automatic fill(input logic signed [AW-1:0] val);
      for (int k = 0; k < NO; k++) a[k] = val;
   endtask

   initial begin
      bit seen;
      rst_n = 1'b0;
      start = 1'b0;
      result_ready = 1'b0;
      acc_in = '0;
      #12;
      check("rst_busy", busy, 0);
      check("rst_valid", result_valid, 0);
      check("rst_idx", class_idx, 0);
      check("rst_score", class_score, 0);
      check("rst_drop", start_dropped, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      a = '{5, -3, 100, 7, 0, 1, 2, 3, 4, -100};
      run(1);
      fill(-7);
      run(0);
      fill(0); a[3] = 50; a[8] = 50;
      run(1);
      fill(MIN_V); a[9] = MAX_V;
      run(0);
`ifdef TLUT_ARGMAX_RUNNER_UP_EN
      fill(0); a[0] = 10; a[1] = 40; a[2] = 40; a[3] = -5;
      run(0);
      fill(MIN_V); a[0] = MAX_V;
      run(0);
`endif

      // Backpressure, dropped start in HOLD, then back-to-back op.
      gen();
      drive_acc();
      model();
      start_op();
      wait_result(0);
      check_result();
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            start = 1'b1;
            #1 check("drop_hold", start_dropped, 1);
         end
         @(posedge clk);
         @(negedge clk);
         start = 1'b0;
         check("bp_valid", result_valid, 1);
         check("bp_idx", class_idx, e_idx);
         check("bp_score", class_score, e_score);
      end
      gen();
      drive_acc();
      model();
      result_ready = 1'b1;
      start_op();
      result_ready = 1'b0;
      check("b2b_busy", busy, 1);
      check("b2b_valid", result_valid, 0);
      wait_result(0);
      check_result();
      finish_op();

      // Reset in the middle of the scan (ptr = 4).
      gen();
      drive_acc();
      start_op();
      repeat (CC + 3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mrst_busy", busy, 0);
      check("mrst_valid", result_valid, 0);
      check("mrst_idx", class_idx, 0);
      check("mrst_score", class_score, 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (LAT + 5) begin
         @(negedge clk);
         seen |= result_valid;
      end
      check("no_partial", seen, 0);
      gen();
      run(0);

      repeat (20) begin
         gen();
         run($urandom_range(0, 1) == 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
